// File: rtl/setup_stim_pkg.sv
// Shared types and widths for the setup/hold stimulus transmitter.
package setup_stim_pkg;

    localparam int CMD_DATA_W   = 1;
    localparam int CMD_CNT_W    = 8;
    localparam int LAUNCH_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_e;

    typedef struct packed {
        logic [CMD_DATA_W-1:0] data;
        logic [CMD_CNT_W-1:0]  setup;
        logic [CMD_CNT_W-1:0]  hold;
        logic                  viol;
    } stim_cmd_t;

endpackage

// File: rtl/setup_stim_cnt.sv
// Loadable down-counter with zero flag; reused for the SETUP and HOLD intervals.
module setup_stim_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/setup_stim_gen.sv
// Launches data, then a reference strobe a programmed number of cycles later.
// Optional feature: define SETUP_STIM_VIOL_EN to allow setup-violating launches.
module setup_stim_gen
    import setup_stim_pkg::*;
#(
    parameter int DATA_W = CMD_DATA_W,
    parameter int CNT_W  = CMD_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [DATA_W-1:0]       cmd_data,
    input  logic [CNT_W-1:0]        cmd_setup,
    input  logic [CNT_W-1:0]        cmd_hold,
    input  logic                    cmd_viol,
    output logic [DATA_W-1:0]       data_out,
    output logic                    ref_out,
    output logic                    busy,
    output logic                    done,
    output logic                    viol_flag,
    output logic [LAUNCH_CNT_W-1:0] launch_cnt
);

    state_e           state, state_nxt;
    stim_cmd_t        cmd_q;
    logic             accept;
    logic             viol_req;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_val;
    logic [CNT_W-1:0] unused_setup;

    // Counter holds cycles remaining after the current one, so load max(s,1)-1.
    function automatic logic [CNT_W-1:0] setup_m1(input logic [CNT_W-1:0] s);
        return (s == '0) ? '0 : s - 1'b1;
    endfunction

`ifdef SETUP_STIM_VIOL_EN
    assign viol_req = cmd_viol;
`else
    logic unused_viol;
    assign unused_viol = cmd_viol;
    assign viol_req    = 1'b0;
`endif

    assign accept       = cmd_valid && (state == IDLE);
    assign unused_setup = cmd_q.setup;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cmd_q      <= '0;
            data_out   <= '0;
            launch_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cmd_q    <= '{data: cmd_data, setup: cmd_setup, hold: cmd_hold, viol: viol_req};
                data_out <= cmd_data;
            end
            if (state == STROBE) begin
                launch_cnt <= launch_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        cnt_val   = '0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (viol_req) begin
                        state_nxt = STROBE;
                    end else begin
                        state_nxt = SETUP;
                        cnt_load  = 1'b1;
                        cnt_val   = setup_m1(cmd_setup);
                    end
                end
            end
            SETUP: begin
                if (cnt_zero) state_nxt = STROBE;
                else          cnt_dec   = 1'b1;
            end
            STROBE: begin
                if (cmd_q.hold != '0) begin
                    state_nxt = HOLD;
                    cnt_load  = 1'b1;
                    cnt_val   = cmd_q.hold - 1'b1;
                end else begin
                    state_nxt = DONE;
                end
            end
            HOLD: begin
                if (cnt_zero) state_nxt = DONE;
                else          cnt_dec   = 1'b1;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    setup_stim_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign cmd_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);
    assign ref_out   = (state == STROBE);
    assign done      = (state == DONE);
    assign viol_flag = ref_out && cmd_q.viol;

endmodule

// File: tb/tb_setup_stim_gen.sv
// Directed bench for setup_stim_gen; expectations are hand-derived cycle offsets from accept.
module tb_setup_stim_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [0:0]  cmd_data;
    logic [7:0]  cmd_setup;
    logic [7:0]  cmd_hold;
    logic        cmd_viol;
    logic [0:0]  data_out;
    logic        ref_out;
    logic        busy;
    logic        done;
    logic        viol_flag;
    logic [15:0] launch_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    setup_stim_gen dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_data   (cmd_data),
        .cmd_setup  (cmd_setup),
        .cmd_hold   (cmd_hold),
        .cmd_viol   (cmd_viol),
        .data_out   (data_out),
        .ref_out    (ref_out),
        .busy       (busy),
        .done       (done),
        .viol_flag  (viol_flag),
        .launch_cnt (launch_cnt)
    );

    // Offer one command and return just after the accepting edge.
    task automatic accept_cmd(input logic d, input logic [7:0] s, input logic [7:0] h, input logic v);
        int guard;
        @(negedge clk);
        cmd_data  = d;
        cmd_setup = s;
        cmd_hold  = h;
        cmd_viol  = v;
        cmd_valid = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (!cmd_ready) begin
            bad++;
            $display("FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        cmd_setup = '0;
        cmd_hold  = '0;
        cmd_viol  = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({data_out, ref_out, busy, done, viol_flag} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b required 00000", {data_out, ref_out, busy, done, viol_flag});
        end
        total++;
        if (launch_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_launch_cnt: got %0d required 0", launch_cnt);
        end
        rst = 1'b0;
        #1;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b required 1", cmd_ready);
        end
    endtask

    task automatic test_basic;
        accept_cmd(1'b1, 8'd3, 8'd2, 1'b0);
        // later changes to the command must not disturb the launch in flight
        cmd_data = 1'b0;
        cmd_hold = 8'd9;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            total += 4;
            if (data_out !== 1'b1) begin
                bad++;
                $display("FAIL basic_data k=%0d: got %b required 1", k, data_out);
            end
            if (ref_out !== (k == 4)) begin
                bad++;
                $display("FAIL basic_ref k=%0d: got %b required %b", k, ref_out, (k == 4));
            end
            if (done !== (k == 7)) begin
                bad++;
                $display("FAIL basic_done k=%0d: got %b required %b", k, done, (k == 7));
            end
            if (busy !== (k <= 7)) begin
                bad++;
                $display("FAIL basic_busy k=%0d: got %b required %b", k, busy, (k <= 7));
            end
        end
        total += 2;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_ready: got %b required 1", cmd_ready);
        end
        if (launch_cnt !== 16'd1) begin
            bad++;
            $display("FAIL basic_launch_cnt: got %0d required 1", launch_cnt);
        end
    endtask

    task automatic test_abort;
        logic saw_done;
        accept_cmd(1'b1, 8'd5, 8'd1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_busy_before: got %b required 1", busy);
        end
        rst = 1'b1;
        #1;
        total += 2;
        if ({data_out, ref_out, busy, done, viol_flag} !== 5'b0) begin
            bad++;
            $display("FAIL abort_outputs: got %b required 00000", {data_out, ref_out, busy, done, viol_flag});
        end
        if (launch_cnt !== 16'd0) begin
            bad++;
            $display("FAIL abort_launch_cnt: got %0d required 0", launch_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_ready: got %b required 1", cmd_ready);
        end
        saw_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            saw_done = saw_done | done | ref_out;
        end
        total++;
        if (saw_done !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_done: got %b required 0", saw_done);
        end
    endtask

    task automatic test_min_setup;
        accept_cmd(1'b1, 8'd0, 8'd0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            total += 4;
            if (ref_out !== (k == 2)) begin
                bad++;
                $display("FAIL min_ref k=%0d: got %b required %b", k, ref_out, (k == 2));
            end
            if (done !== (k == 3)) begin
                bad++;
                $display("FAIL min_done k=%0d: got %b required %b", k, done, (k == 3));
            end
            if (viol_flag !== 1'b0) begin
                bad++;
                $display("FAIL min_viol k=%0d: got %b required 0", k, viol_flag);
            end
            if (cmd_ready !== (k == 4)) begin
                bad++;
                $display("FAIL min_ready k=%0d: got %b required %b", k, cmd_ready, (k == 4));
            end
        end
    endtask

    task automatic test_back_to_back;
        logic exp_ref, exp_done, exp_ready;
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        cmd_data  = 1'b1;
        cmd_setup = 8'd1;
        cmd_hold  = 8'd1;
        cmd_viol  = 1'b0;
        cmd_valid = 1'b1;
        // first accept happens at the next edge; each launch then spans 5 cycles
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            exp_ref   = (k == 2) || (k == 7) || (k == 12);
            exp_done  = (k == 4) || (k == 9) || (k == 14);
            exp_ready = (k == 5) || (k == 10) || (k == 15);
            total += 3;
            if (ref_out !== exp_ref) begin
                bad++;
                $display("FAIL b2b_ref k=%0d: got %b required %b", k, ref_out, exp_ref);
            end
            if (done !== exp_done) begin
                bad++;
                $display("FAIL b2b_done k=%0d: got %b required %b", k, done, exp_done);
            end
            if (cmd_ready !== exp_ready) begin
                bad++;
                $display("FAIL b2b_ready k=%0d: got %b required %b", k, cmd_ready, exp_ready);
            end
            if (k == 14) cmd_valid = 1'b0;
        end
        total++;
        if (launch_cnt !== 16'd3) begin
            bad++;
            $display("FAIL b2b_launch_cnt: got %0d required 3", launch_cnt);
        end
    endtask

    task automatic test_wrap;
        @(negedge clk);
        force dut.launch_cnt = 16'hFFFF;
        #1 release dut.launch_cnt;
        accept_cmd(1'b0, 8'd1, 8'd0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            total++;
            if (ref_out !== (k == 2)) begin
                bad++;
                $display("FAIL wrap_ref k=%0d: got %b required %b", k, ref_out, (k == 2));
            end
        end
        total++;
        if (launch_cnt !== 16'd0) begin
            bad++;
            $display("FAIL wrap_launch_cnt: got %h required 0000", launch_cnt);
        end
    endtask

    task automatic test_viol;
        int s_exp;
        logic v_exp;
`ifdef SETUP_STIM_VIOL_EN
        s_exp = 0;
        v_exp = 1'b1;
`else
        s_exp = 5;
        v_exp = 1'b0;
`endif
        accept_cmd(1'b1, 8'd5, 8'd1, 1'b1);
        cmd_viol = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            total += 4;
            if (data_out !== 1'b1) begin
                bad++;
                $display("FAIL viol_data k=%0d: got %b required 1", k, data_out);
            end
            if (ref_out !== (k == 1 + s_exp)) begin
                bad++;
                $display("FAIL viol_ref k=%0d: got %b required %b", k, ref_out, (k == 1 + s_exp));
            end
            if (viol_flag !== (v_exp && (k == 1 + s_exp))) begin
                bad++;
                $display("FAIL viol_flag k=%0d: got %b required %b", k, viol_flag, (v_exp && (k == 1 + s_exp)));
            end
            if (done !== (k == 3 + s_exp)) begin
                bad++;
                $display("FAIL viol_done k=%0d: got %b required %b", k, done, (k == 3 + s_exp));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_abort();
        test_min_setup();
        test_back_to_back();
        test_wrap();
        test_viol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
